// File: rtl/tt_um_ternary_mac_if.sv
// Handshake and data bundle between the weight-load stage, the activation source and the ternary MAC.
// The master side drives the weights and activations. The slave side is the MAC engine.
interface tt_um_ternary_mac_if #(
   parameter int MAX_IN_LEN   = 16,
   parameter int MAX_OUT_LEN  = 8,
   parameter int WIDTH        = 2,
   parameter int ACT_WIDTH    = 8,
   parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
   parameter int ACC_WIDTH    = ACT_WIDTH + $clog2(MAX_IN_LEN) + 1
);
   logic                                    start;
   logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights;
   logic signed [ACT_WIDTH-1:0]             act_in;
   logic                                    act_valid;
   logic signed [ACC_WIDTH-1:0]             result;
   logic [MAX_OUT_BITS-1:0]                 result_idx;
   logic                                    result_valid;
   logic                                    busy;
   logic                                    done;

   modport master (
      output start, weights, act_in, act_valid,
      input  result, result_idx, result_valid, busy, done
   );

   modport slave (
      input  start, weights, act_in, act_valid,
      output result, result_idx, result_valid, busy, done
   );
endinterface

// File: rtl/tt_um_ternary_mac.sv
// Ternary matrix-vector engine. One signed accumulator per output neuron is updated in parallel for each activation.
// The finished dot products are then streamed out one neuron per cycle.
module tt_um_ternary_mac_lane #(
   parameter int WIDTH     = 2,
   parameter int ACT_WIDTH = 8,
   parameter int ACC_WIDTH = 13
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        clr,
   input  logic                        upd,
   input  logic [WIDTH-1:0]            w,
   input  logic signed [ACT_WIDTH-1:0] act,
   output logic signed [ACC_WIDTH-1:0] acc
);
   logic signed [ACC_WIDTH-1:0] act_ext;

   assign act_ext = ACC_WIDTH'(act);

   // Bit 0 marks a non-zero weight. Bit 1 selects the sign, so 2'b10 decodes as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         if (clr) begin
            acc <= '0;
         end else if (upd && w[0]) begin
            acc <= w[1] ? acc - act_ext : acc + act_ext;
         end
      end
   end
endmodule

module tt_um_ternary_mac #(
   parameter int MAX_IN_LEN   = 16,
   parameter int MAX_OUT_LEN  = 8,
   parameter int WIDTH        = 2,
   parameter int ACT_WIDTH    = 8,
   parameter int MAX_IN_BITS  = $clog2(MAX_IN_LEN),
   parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
   parameter int ACC_WIDTH    = ACT_WIDTH + MAX_IN_BITS + 1
) (
   input logic               clk,
   input logic               rst,
   input logic               ena,
   tt_um_ternary_mac_if.slave bus
);
   localparam logic [MAX_IN_BITS-1:0]  LAST_IN  = MAX_IN_BITS'(MAX_IN_LEN - 1);
   localparam logic [MAX_OUT_BITS-1:0] LAST_OUT = MAX_OUT_BITS'(MAX_OUT_LEN - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t                                   state, state_nxt;
   logic [MAX_IN_BITS-1:0]                   in_cnt;
   logic [MAX_OUT_BITS-1:0]                  out_cnt;
   logic                                     clr, upd, emit;
   logic [MAX_OUT_LEN-1:0][WIDTH-1:0]        row_w;
   logic [MAX_OUT_LEN-1:0][ACC_WIDTH-1:0]    accs;

   // Weights are read straight off the load-stage bus, one matrix row per accepted activation.
   for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_lane
      assign row_w[j] = bus.weights[(int'(in_cnt)*MAX_OUT_LEN + j)*WIDTH +: WIDTH];

      tt_um_ternary_mac_lane #(
         .WIDTH     (WIDTH),
         .ACT_WIDTH (ACT_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .en  (ena),
         .clr (clr),
         .upd (upd),
         .w   (row_w[j]),
         .act (bus.act_in),
         .acc (accs[j])
      );
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      upd       = 1'b0;
      emit      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               clr       = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.act_valid) begin
               upd = 1'b1;
               if (in_cnt == LAST_IN) state_nxt = OUTPUT;
            end
         end
         OUTPUT: begin
            emit = 1'b1;
            if (out_cnt == LAST_OUT) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A disabled cycle still drops the valid and done strobes so a frozen result is never reported twice.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         in_cnt           <= '0;
         out_cnt          <= '0;
         bus.result       <= '0;
         bus.result_idx   <= '0;
         bus.result_valid <= 1'b0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
      end else if (ena) begin
         state            <= state_nxt;
         bus.busy         <= (state_nxt != IDLE);
         bus.result_valid <= emit;
         bus.done         <= emit && (out_cnt == LAST_OUT);
         if (clr)      in_cnt <= '0;
         else if (upd) in_cnt <= in_cnt + 1'b1;
         if (upd && in_cnt == LAST_IN) out_cnt <= '0;
         else if (emit)                out_cnt <= out_cnt + 1'b1;
         if (emit) begin
            bus.result     <= accs[out_cnt];
            bus.result_idx <= out_cnt;
         end
      end else begin
         bus.result_valid <= 1'b0;
         bus.done         <= 1'b0;
      end
   end
endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Randomized bench for the ternary MAC. Expected dot products come from plain nested sums over the weight codes.
// The result stream is scoreboarded against those sums.
module tb_tt_um_ternary_mac;
   localparam int NI = 16;
   localparam int NO = 8;

   logic clk = 1'b0;
   logic rst, ena;

   tt_um_ternary_mac_if bus ();

   tt_um_ternary_mac dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   int  cur_code [NI][NO];
   int  cur_act  [NI];
   int  exp_res  [NO];
   int  exp_idx;
   int  got_cnt;
   bit  out_phase;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   function automatic int tval(input int code);
      case (code & 3)
         1:       return 1;
         3:       return -1;
         default: return 0;
      endcase
   endfunction

   // One clock: inputs are already set up; the outputs are inspected 1 ns after the edge.
   task automatic step();
      bit ena_edge;
      ena_edge = ena;
      @(posedge clk);
      #1;
      chk("done_only_with_valid", 32'(bus.done & ~bus.result_valid), 0);
      if (!ena_edge) chk("valid_while_ena_low", 32'(bus.result_valid), 0);
      if (bus.result_valid) begin
         if (!out_phase || exp_idx >= NO) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            chk("result_idx", 32'(bus.result_idx), exp_idx);
            chk("result", int'($signed(bus.result)), exp_res[exp_idx]);
            chk("done", 32'(bus.done), (exp_idx == NO-1) ? 1 : 0);
            exp_idx++;
            got_cnt++;
         end
      end
   endtask

   task automatic load_weights();
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NO; j++)
            bus.weights[(i*NO + j)*2 +: 2] = 2'(cur_code[i][j]);
      for (int j = 0; j < NO; j++) begin
         exp_res[j] = 0;
         for (int i = 0; i < NI; i++) exp_res[j] += cur_act[i] * tval(cur_code[i][j]);
      end
   endtask

   // One full vector. gaps inserts idle cycles that carry stray starts. pause_at (>=1) freezes ena mid-stream.
   task automatic run_vector(input bit gaps, input int pause_at, input bit junk);
      int a8;
      load_weights();
      exp_idx = 0; got_cnt = 0; out_phase = 0;
      if (junk) begin
         bus.act_valid = 1'b1; bus.act_in = 8'sd99;
         step();
         chk("busy_idle_act", 32'(bus.busy), 0);
      end
      bus.start = 1'b1;
      bus.act_valid = junk; bus.act_in = 8'sd77;
      step();
      chk("busy_after_start", 32'(bus.busy), 1);
      bus.start = 1'b0;
      for (int i = 0; i < NI; i++) begin
         if (gaps) begin
            bus.act_valid = 1'b0;
            bus.act_in = 8'($urandom_range(0, 255));
            bus.start = 1'($urandom_range(0, 1));
            step();
            bus.start = 1'b0;
         end
         a8 = cur_act[i];
         bus.act_valid = 1'b1; bus.act_in = a8[7:0];
         step();
      end
      out_phase = 1;
      bus.act_valid = gaps; bus.act_in = 8'sd55;
      step();
      chk("first_result_latency", got_cnt, 1);
      for (int k = 0; k < 40 && got_cnt < NO; k++) begin
         if (pause_at > 0 && got_cnt == pause_at) begin
            pause_at = -1;
            ena = 1'b0;
            repeat (3) step();
            ena = 1'b1;
         end
         step();
      end
      chk("result_count", got_cnt, NO);
      chk("busy_after_done", 32'(bus.busy), 0);
      out_phase = 0;
      bus.act_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1;
      bus.start = 1'b0; bus.act_valid = 1'b0; bus.act_in = '0; bus.weights = '0;
      exp_idx = 0; got_cnt = 0; out_phase = 0;
      step(); step();
      chk("rst_result", int'($signed(bus.result)), 0);
      chk("rst_idx", 32'(bus.result_idx), 0);
      chk("rst_valid", 32'(bus.result_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      rst = 1'b0;

      // all +1, ramp 1..16
      for (int i = 0; i < NI; i++) begin
         cur_act[i] = i + 1;
         for (int j = 0; j < NO; j++) cur_code[i][j] = 1;
      end
      run_vector(0, -1, 0);
      chk("ramp_sum", exp_res[0], 136);

      // all -1 against the most negative activation
      for (int i = 0; i < NI; i++) begin
         cur_act[i] = -128;
         for (int j = 0; j < NO; j++) cur_code[i][j] = 3;
      end
      run_vector(0, -1, 0);
      chk("max_pos_sum", exp_res[NO-1], 2048);

      // alternating signs on the low rows, zero codes on the high rows
      for (int i = 0; i < NI; i++) begin
         cur_act[i] = i + 1;
         for (int j = 0; j < NO; j++)
            cur_code[i][j] = (i >= 8) ? ((i + j) % 2) * 2 : ((i % 2) ? 3 : 1);
      end
      run_vector(0, -1, 0);
      chk("mixed_sum", exp_res[3], -4);

      // ramp again with activation gaps and an ena freeze during output
      for (int i = 0; i < NI; i++) begin
         cur_act[i] = i + 1;
         for (int j = 0; j < NO; j++) cur_code[i][j] = 1;
      end
      run_vector(1, 3, 1);

      // reset after 5 activations, then a clean random vector
      bus.start = 1'b1; step(); bus.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.act_valid = 1'b1; bus.act_in = 8'sd100; step();
      end
      bus.act_valid = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_result", int'($signed(bus.result)), 0);

      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < NI; i++) begin
            cur_act[i] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < NO; j++) cur_code[i][j] = int'($urandom_range(0, 3));
         end
         run_vector(1'(v % 2), (v % 3 == 0) ? int'($urandom_range(1, NO-1)) : -1, 1'(v % 2 == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/tt_um_ternary_mac.md
Name: tt_um_ternary_mac

Overview:
- Ternary matrix-vector engine directly downstream of the weight-load stage.
- Consumes the packed 2-bit ternary weight bus (MAX_IN_LEN x MAX_OUT_LEN) and a serial stream of MAX_IN_LEN signed activations.
- Accumulates one signed dot product per output neuron.
- Streams the MAX_OUT_LEN results out serially, one per cycle, tagged with the neuron index.

Parameters:
- MAX_IN_LEN, 16, activations per vector (rows of the weight matrix)
- MAX_OUT_LEN, 8, output neurons (columns)
- WIDTH, 2, bits per ternary weight
- ACT_WIDTH, 8, signed activation width
- MAX_IN_BITS, $clog2(MAX_IN_LEN), input counter width
- MAX_OUT_BITS, $clog2(MAX_OUT_LEN), output counter width
- ACC_WIDTH, ACT_WIDTH+MAX_IN_BITS+1, signed accumulator/result width (13 by default)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ena  input  1  global enable; when low, all state and outputs hold
- start  input  1  begin a vector; sampled only in IDLE
- weights  input  WIDTH*MAX_IN_LEN*MAX_OUT_LEN  packed ternary weights from the load stage
- act_in  input  ACT_WIDTH  signed activation
- act_valid  input  1  act_in is valid this cycle
- result  output  ACC_WIDTH  signed dot product for neuron result_idx
- result_idx  output  MAX_OUT_BITS  neuron index of result
- result_valid  output  1  result/result_idx valid
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse coinciding with the last result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE; all accumulators, in_cnt and out_cnt = 0.
  - result=0, result_idx=0, result_valid=0, busy=0, done=0.
- Weight addressing: the weight for input i, neuron j is weights[(i*MAX_OUT_LEN + j)*WIDTH +: WIDTH].
- Weight decode: 2'b01 = +1; 2'b11 = -1; 2'b00 and 2'b10 = 0.
- Weight stability: the block holds no copy of the weights. The weights bus must stay stable from the start cycle until done.
- Arithmetic:
  - act_in is sign-extended to ACC_WIDTH, then added, subtracted or skipped per weight.
  - No saturation. ACC_WIDTH covers the full range: 16 x (-128) x (-1) = +2048 fits without overflow.
- FSM transitions (all gated by ena=1):
  - IDLE: on start=1, clear all MAX_OUT_LEN accumulators, in_cnt=0, go to ACCUM. busy rises the following cycle.
  - ACCUM: on each act_valid=1 cycle, update every accumulator in parallel with row in_cnt, then in_cnt++. Cycles with act_valid=0 change nothing.
  - ACCUM exit: on the cycle the activation with in_cnt==MAX_IN_LEN-1 is consumed, go to OUTPUT with out_cnt=0.
  - OUTPUT: each cycle, register result=acc[out_cnt], result_idx=out_cnt, result_valid=1, then out_cnt++.
  - OUTPUT exit: when out_cnt==MAX_OUT_LEN-1, also assert done=1 and go to IDLE.
- Output timing:
  - Registered outputs.
  - First result_valid appears 1 cycle after the last activation is accepted.
  - Results arrive on MAX_OUT_LEN consecutive enabled cycles, index ascending 0..MAX_OUT_LEN-1.
  - result_valid and done are 0 in all other cycles.
  - result and result_idx hold their last values when not valid.
- Boundary conditions:
  - start while busy: ignored.
  - act_valid in IDLE or OUTPUT: ignored.
  - start and act_valid together in IDLE: only start takes effect; that activation is not consumed.
  - ena=0: freezes state, counters and accumulators; result_valid=0 and done=0 that cycle. The output sequence resumes with the same index when ena returns.
  - rst mid-operation: immediate return to IDLE with reset values; the partial vector is discarded.
- Back-to-back vectors: start may be asserted on the cycle after done.

Test Plan:
- All weights 2'b01, act_in=1..16 with continuous act_valid → results 136 for idx 0..7, result_valid on 8 consecutive cycles, done with idx 7.
- All weights 2'b11, every act_in=-128 → every result +2048 (13'h0800), no wrap.
- Mixed weights: neuron j uses +1 on even rows, -1 on odd rows, and 2'b00/2'b10 on rows ≥8; act_in=i+1 → every result -4.
- act_valid gaps every other cycle plus ena low for 3 cycles during OUTPUT → same results as the gap-free run; index sequence unbroken; no result_valid while ena=0.
- rst asserted after 5 activations → busy=0 next cycle; a new start with 16 activations gives clean results with no carry-over.
- start pulsed during ACCUM and act_valid pulsed in IDLE → both ignored; exactly 16 activations are consumed after the real start.
